// File: rtl/cpu_prefetch_unit.sv
// cpu_prefetch_unit: instruction fetch front end.
// Owns the fetch PC and issues single-outstanding byte reads over a
// ready-based handshake. Bytes land in a DEPTH-entry FIFO, and complete
// two-byte words are presented to the decoder, tagged with their PC.
// A redirect flushes the buffer, cancels any pending read and restarts fetch.
module cpu_prefetch_unit #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 16,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h2000
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic                   mem_r,
   input  logic [DATA_W-1:0]      mem_rdata,
   input  logic                   mem_ready,
   input  logic                   redirect,
   input  logic [ADDR_W-1:0]      redirect_pc,
   input  logic                   fetch_hold,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [2*DATA_W-1:0]    instr_word,
   output logic [ADDR_W-1:0]      instr_pc,
   output logic [$clog2(DEPTH):0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic                req_r;
   logic                req_nxt_s;
   logic [ADDR_W-1:0]   addr_r;
   logic [ADDR_W-1:0]   addr_nxt_s;
   logic [ADDR_W-1:0]   fetch_pc_r;
   logic [ADDR_W-1:0]   fetch_pc_nxt_s;

   logic [DATA_W-1:0]   fifo_r [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_nxt1_s;
   logic [LVL_W-1:0]    level_r;
   logic [LVL_W-1:0]    level_nxt_s;
   logic [ADDR_W-1:0]   instr_pc_r;

   logic                valid_s;
   logic                push_s;
   logic                pop_s;

   // A redirect wins over both a completing read and a decoder accept.
   assign valid_s       = (level_r >= LVL_W'(2));
   assign push_s        = (state_r == ST_REQ) && mem_ready && !redirect;
   assign pop_s         = valid_s && instr_ready && !redirect;
   assign rd_ptr_nxt1_s = rd_ptr_r + PTR_W'(1);

   assign mem_r       = req_r;
   assign mem_addr    = addr_r;
   assign instr_valid = valid_s;
   assign instr_word  = {fifo_r[rd_ptr_r], fifo_r[rd_ptr_nxt1_s]};
   assign instr_pc    = instr_pc_r;
   assign level       = level_r;

   // Occupancy after this edge's push and pop, used to decide back-to-back issue.
   always_comb begin
      level_nxt_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_W'(1);
         2'b01:   level_nxt_s = level_r - LVL_W'(2);
         2'b11:   level_nxt_s = level_r - LVL_W'(1);
         default: level_nxt_s = level_r;
      endcase
   end

   // Bus FSM next state: issue only with a guaranteed slot, continue back-to-back when allowed.
   always_comb begin
      state_nxt_s    = state_r;
      req_nxt_s      = req_r;
      addr_nxt_s     = addr_r;
      fetch_pc_nxt_s = fetch_pc_r;
      if (redirect) begin
         state_nxt_s    = ST_IDLE;
         req_nxt_s      = 1'b0;
         fetch_pc_nxt_s = redirect_pc;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!fetch_hold && (level_r < LVL_W'(DEPTH))) begin
                  state_nxt_s = ST_REQ;
                  req_nxt_s   = 1'b1;
                  addr_nxt_s  = fetch_pc_r;
               end else begin
                  state_nxt_s = ST_IDLE;
                  req_nxt_s   = 1'b0;
               end
            end
            ST_REQ: begin
               if (mem_ready) begin
                  fetch_pc_nxt_s = fetch_pc_r + ADDR_W'(1);
                  if (!fetch_hold && (level_nxt_s < LVL_W'(DEPTH))) begin
                     state_nxt_s = ST_REQ;
                     req_nxt_s   = 1'b1;
                     addr_nxt_s  = fetch_pc_r + ADDR_W'(1);
                  end else begin
                     state_nxt_s = ST_IDLE;
                     req_nxt_s   = 1'b0;
                  end
               end else begin
                  state_nxt_s = ST_REQ;
                  req_nxt_s   = 1'b1;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               req_nxt_s   = 1'b0;
            end
         endcase
      end
   end

   // Bus FSM state, request and address registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         req_r      <= 1'b0;
         addr_r     <= RESET_PC;
         fetch_pc_r <= RESET_PC;
      end else begin
         state_r    <= state_nxt_s;
         req_r      <= req_nxt_s;
         addr_r     <= addr_nxt_s;
         fetch_pc_r <= fetch_pc_nxt_s;
      end
   end

   // FIFO pointers, occupancy and head-word PC; redirect empties the buffer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         level_r    <= '0;
         instr_pc_r <= RESET_PC;
      end else if (redirect) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         level_r    <= '0;
         instr_pc_r <= redirect_pc;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r   <= rd_ptr_r + PTR_W'(2);
            instr_pc_r <= instr_pc_r + ADDR_W'(2);
         end
         level_r <= level_nxt_s;
      end
   end

   // FIFO byte storage; only completed, non-redirected reads are written.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_r[wr_ptr_r] <= mem_rdata;
      end
   end

endmodule
